timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
Shares one 32-bit cycle stopwatch (start/stop/value interface) between NUM_REQ requesters. Requesters measure interval lengths, such as DMA or FFT processing latency. The block grants the stopwatch round-robin, pulses start on grant, and pulses stop when the granted requester signals done or a timeout expires. It then captures the count and returns it with the requester ID and an ack pulse. It sits between the stopwatch instance and the measurement clients in the ml605 top level.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of result_id; must equal clog2(NUM_REQ)
TIMEOUT, 32'd100_000_000, max measured cycles before forced stop (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  level request per requester; held until its ack
done  in  NUM_REQ  end-of-interval pulse per requester
grant  out  NUM_REQ  one-hot; current stopwatch owner
ack  out  NUM_REQ  one-cycle completion pulse to owner
result  out  32  captured cycle count
result_id  out  ID_W  index of requester that produced result
result_timeout  out  1  1 = measurement ended by timeout
busy  out  1  high whenever state != IDLE
tmr_start  out  1  stopwatch start strobe
tmr_stop  out  1  stopwatch stop strobe
tmr_value  in  32  stopwatch count

Behaviour:
- Stopwatch contract:
  - start sampled at edge k loads 0.
  - Count increments every edge while running.
  - stop sampled at edge m still increments, then holds.
  - Held value = m-k.
- All outputs are registered.
- rst (async) clears everything immediately: every output 0, state IDLE, rr pointer 0, cycle counter 0. The stopwatch shares rst.
- States: IDLE, RUN, STOP, CAPTURE, ACK.
- IDLE:
  - At each edge, if req != 0, select the first set bit scanning upward from the rr pointer, with wrap.
  - On that edge (e0): grant = onehot(sel), tmr_start = 1, cnt = 0, go to RUN.
- RUN:
  - tmr_start = 0 after the first RUN edge.
  - cnt increments each edge.
  - If done[sel] is sampled at edge d: tmr_stop = 1, tout = 0, go to STOP.
  - Else if cnt reaches TIMEOUT (edge e0+TIMEOUT): tmr_stop = 1, tout = 1, go to STOP.
  - done and timeout on the same edge: done wins, tout = 0.
  - done bits of non-granted requesters are ignored.
  - Deassertion of req[sel] during RUN is ignored; the measurement still completes and acks.
- STOP: tmr_stop is high for exactly this cycle; the next edge clears it and goes to CAPTURE.
- CAPTURE:
  - tmr_value is stable.
  - Next edge: result <= tmr_value, result_id <= sel, result_timeout <= tout, ack[sel] <= 1, go to ACK.
- ACK:
  - ack is high for one cycle; grant is still held.
  - Next edge: ack = 0, grant = 0, rr pointer = (sel+1) mod NUM_REQ, go to IDLE.
  - No arbitration occurs on this edge; requesters drop req on the edge ending ACK.
- Measured value:
  - result = d - e0, i.e. edges from grant edge to done-sampling edge. Minimum 1 (done sampled on the first RUN edge).
  - On timeout, result = TIMEOUT.
- result, result_id and result_timeout hold until the next capture.
- Turnaround: ack to next possible grant is 1 IDLE edge.
- cnt is 32-bit, saturating-irrelevant since it is bounded by TIMEOUT.
- Illegal state: go to IDLE, grant 0, tmr_start 0, tmr_stop 0.

Test Plan:
1. Requester 0 alone, done[0] pulsed at edge e0+10, with behavioural stopwatch model -> tmr_start 1 cycle after e0; tmr_stop 1 cycle; ack[0] single cycle; result=10, result_id=0, result_timeout=0; busy low again 1 cycle after ack.
2. req=4'b0101 raised together, pointer 0 -> req0 served first (pointer becomes 1), then req2 (pointer becomes 3). req0 and req2 re-raised -> req0 served before req2; grant is never multi-hot.
3. TIMEOUT=16, req1 granted, no done -> tmr_stop at edge e0+16; result=16, result_timeout=1, result_id=1.
4. TIMEOUT=16, done[1] sampled exactly at edge e0+16 -> result=16, result_timeout=0.
5. done[3] pulsed while requester 1 owns the stopwatch -> no effect. Then done[1] sampled on the first RUN edge -> result=1.
6. rst asserted mid-RUN -> grant, tmr_start, tmr_stop, ack and busy go to 0 without waiting for clk. After release, simultaneous req=4'b1010 -> req1 granted first (pointer back to 0).

Source files
------------

// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one 32-bit cycle stopwatch among NUM_REQ requesters.
// The stopwatch is granted round-robin and pulsed to start on the grant edge.
// It is pulsed to stop on the owner's done or on timeout. The captured count
// is returned with the owner's ID and a one-cycle ack.
//
// state   | meaning
// IDLE    | no owner; arbitrate among pending requests
// RUN     | stopwatch running for sel; wait for done[sel] or timeout
// STOP    | tmr_stop high for this one cycle
// CAPTURE | stopwatch has settled; latch its value on the next edge
// ACK     | ack[sel] high; release grant and advance rr pointer next edge
module timer_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter int          ID_W    = 2,
    parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] ack,
    output logic [31:0]        result,
    output logic [ID_W-1:0]    result_id,
    output logic               result_timeout,
    output logic               busy,
    output logic               tmr_start,
    output logic               tmr_stop,
    input  logic [31:0]        tmr_value
);

    typedef enum logic [2:0] {IDLE, RUN, STOP, CAPTURE, ACK} state_t;

    localparam logic [ID_W:0] N_REQ = NUM_REQ[ID_W:0];

    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]    sel, sel_nxt;
    logic [31:0]        cnt, cnt_nxt;
    logic               tout, tout_nxt;
    logic [NUM_REQ-1:0] grant_nxt, ack_nxt;
    logic [31:0]        result_nxt;
    logic [ID_W-1:0]    result_id_nxt;
    logic               result_timeout_nxt, busy_nxt, tmr_start_nxt, tmr_stop_nxt;

    logic [ID_W-1:0]    pick;
    logic               found;
    logic [ID_W:0]      scan_sum;
    logic [ID_W:0]      sel_inc;
    logic [31:0]        cnt_inc;

    // Round-robin pick: walk offsets downward so the smallest offset from rr_ptr wins.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_sum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan_sum >= N_REQ) scan_sum = scan_sum - N_REQ;
            if (req[scan_sum[ID_W-1:0]]) begin
                pick  = scan_sum[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt + 32'd1;
    assign sel_inc = {1'b0, sel} + {{ID_W{1'b0}}, 1'b1};

    // Next-state and next-output logic; every registered value defaults to hold.
    always_comb begin
        state_nxt          = state;
        rr_ptr_nxt         = rr_ptr;
        sel_nxt            = sel;
        cnt_nxt            = cnt;
        tout_nxt           = tout;
        grant_nxt          = grant;
        ack_nxt            = '0;
        result_nxt         = result;
        result_id_nxt      = result_id;
        result_timeout_nxt = result_timeout;
        tmr_start_nxt      = 1'b0;
        tmr_stop_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt         = pick;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    tmr_start_nxt   = 1'b1;
                    cnt_nxt         = '0;
                    state_nxt       = RUN;
                end
            end
            RUN: begin
                cnt_nxt = cnt_inc;
                // done takes priority over a timeout on the same edge
                if (done[sel]) begin
                    tmr_stop_nxt = 1'b1;
                    tout_nxt     = 1'b0;
                    state_nxt    = STOP;
                end else if (cnt_inc == TIMEOUT) begin
                    tmr_stop_nxt = 1'b1;
                    tout_nxt     = 1'b1;
                    state_nxt    = STOP;
                end
            end
            STOP: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                result_nxt         = tmr_value;
                result_id_nxt      = sel;
                result_timeout_nxt = tout;
                ack_nxt[sel]       = 1'b1;
                state_nxt          = ACK;
            end
            ACK: begin
                grant_nxt  = '0;
                rr_ptr_nxt = (sel_inc == N_REQ) ? '0 : sel_inc[ID_W-1:0];
                state_nxt  = IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            sel            <= '0;
            cnt            <= '0;
            tout           <= 1'b0;
            grant          <= '0;
            ack            <= '0;
            result         <= '0;
            result_id      <= '0;
            result_timeout <= 1'b0;
            busy           <= 1'b0;
            tmr_start      <= 1'b0;
            tmr_stop       <= 1'b0;
        end else begin
            state          <= state_nxt;
            rr_ptr         <= rr_ptr_nxt;
            sel            <= sel_nxt;
            cnt            <= cnt_nxt;
            tout           <= tout_nxt;
            grant          <= grant_nxt;
            ack            <= ack_nxt;
            result         <= result_nxt;
            result_id      <= result_id_nxt;
            result_timeout <= result_timeout_nxt;
            busy           <= busy_nxt;
            tmr_start      <= tmr_start_nxt;
            tmr_stop       <= tmr_stop_nxt;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Testbench for timer_arbiter with a behavioural stopwatch and a result scoreboard.
module tb_timer_arbiter;

    localparam int TO = 16;

    logic        clk, rst;
    logic [3:0]  req, done, grant, ack;
    logic [31:0] result, tmr_value;
    logic [1:0]  result_id;
    logic        result_timeout, busy, tmr_start, tmr_stop;

    logic [31:0] sw_val;
    logic        sw_run;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;
        int d;       // done sampled at edge e0+d; 0 = never (timeout)
        int exp_res;
        bit exp_tout;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
        logic        tout;
    } exp_t;

    vec_t vecs[5];
    exp_t sbq[$];

    timer_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(32'(TO))) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .grant(grant), .ack(ack),
        .result(result), .result_id(result_id), .result_timeout(result_timeout),
        .busy(busy), .tmr_start(tmr_start), .tmr_stop(tmr_stop), .tmr_value(tmr_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural stopwatch: start loads 0, increments while running, stop increments once more then holds.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_val <= '0;
            sw_run <= 1'b0;
        end else if (tmr_start) begin
            sw_val <= '0;
            sw_run <= 1'b1;
        end else if (sw_run) begin
            sw_val <= sw_val + 32'd1;
            if (tmr_stop) sw_run <= 1'b0;
        end
    end
    assign tmr_value = sw_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait for grant to id, time done, check stop strobe, wait for ack, release req.
    task automatic serve(input int id, input int d, input logic [3:0] noise,
                         input int exp_res, input bit exp_tout);
        int   n;
        int   pos;
        exp_t e;
        n = 0;
        while (grant == 4'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("grant_wait", 32'(grant != 4'b0), 1);
        if (grant == 4'b0) return;
        chk("grant_id", 32'(grant), 32'(4'b1 << id));
        chk("start_on_grant", 32'(tmr_start), 1);
        chk("busy_run", 32'(busy), 1);
        e.id = 2'(id); e.res = 32'(exp_res); e.tout = exp_tout;
        sbq.push_back(e);
        pos = 0;
        if (d > 0) begin
            while (pos < d - 1) begin
                done = (pos == 0) ? noise : 4'b0;
                @(negedge clk);
                done = 4'b0;
                pos++;
            end
            done = ((pos == 0) ? noise : 4'b0) | (4'b1 << id);
            @(negedge clk);
            done = 4'b0;
            chk("stop_at_done", 32'(tmr_stop), 1);
        end else begin
            repeat (TO - 1) @(negedge clk);
            chk("stop_before_to", 32'(tmr_stop), 0);
            @(negedge clk);
            chk("stop_at_to", 32'(tmr_stop), 1);
        end
        @(negedge clk);
        chk("stop_one_cycle", 32'(tmr_stop), 0);
        n = 0;
        while (ack == 4'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ack_wait", 32'(ack != 4'b0), 1);
        req[id] = 1'b0;
        @(negedge clk);
        chk("busy_after_ack", 32'(busy), 0);
        chk("grant_released", 32'(grant), 0);
    endtask

    initial begin
        logic       prev_start, prev_stop;
        logic [3:0] prev_ack;
        int         n;

        vecs[0] = '{id: 0, d: 10, exp_res: 10, exp_tout: 1'b0};
        vecs[1] = '{id: 1, d: 0,  exp_res: TO, exp_tout: 1'b1};
        vecs[2] = '{id: 1, d: TO, exp_res: TO, exp_tout: 1'b0};
        vecs[3] = '{id: 2, d: 1,  exp_res: 1,  exp_tout: 1'b0};
        vecs[4] = '{id: 3, d: 5,  exp_res: 5,  exp_tout: 1'b0};

        rst = 1'b1; req = 4'b0; done = 4'b0;

        // Monitor: pulse widths, one-hot grant, scoreboard on ack.
        fork
            begin
                prev_start = 1'b0; prev_stop = 1'b0; prev_ack = 4'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_start = 1'b0; prev_stop = 1'b0; prev_ack = 4'b0;
                    end else begin
                        if (grant != 4'b0) chk("grant_onehot", 32'($countones(grant)), 1);
                        if (tmr_start) chk("start_width", 32'(prev_start), 0);
                        if (tmr_stop)  chk("stop_width", 32'(prev_stop), 0);
                        if (ack != 4'b0) begin
                            chk("ack_width", 32'(prev_ack), 0);
                            chk("ack_eq_grant", 32'(ack), 32'(grant));
                            chk("sb_has_entry", 32'(sbq.size() != 0), 1);
                            if (sbq.size() != 0) begin
                                exp_t e;
                                e = sbq.pop_front();
                                chk("ack_onehot_id", 32'(ack), 32'(4'b1 << e.id));
                                chk("result", result, e.res);
                                chk("result_id", 32'(result_id), 32'(e.id));
                                chk("result_timeout", 32'(result_timeout), 32'(e.tout));
                            end
                        end
                        prev_start = tmr_start; prev_stop = tmr_stop; prev_ack = ack;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_result", result, 0);
        chk("rst_result_id", 32'(result_id), 0);
        chk("rst_result_timeout", 32'(result_timeout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tmr_start", 32'(tmr_start), 0);
        chk("rst_tmr_stop", 32'(tmr_stop), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single-requester measurements: done latency, timeout, done at timeout edge.
        for (int v = 0; v < 5; v++) begin
            req[vecs[v].id] = 1'b1;
            serve(vecs[v].id, vecs[v].d, 4'b0, vecs[v].exp_res, vecs[v].exp_tout);
        end

        // Round-robin with two simultaneous requesters, pointer starting at 0.
        req = 4'b0101;
        serve(0, 4, 4'b0, 4, 1'b0);
        serve(2, 3, 4'b0, 3, 1'b0);
        req = 4'b0101;
        serve(0, 2, 4'b0, 2, 1'b0);
        serve(2, 6, 4'b0, 6, 1'b0);

        // Non-owner done ignored; then done on the first RUN edge.
        req[1] = 1'b1;
        serve(1, 8, 4'b1000, 8, 1'b0);
        req[1] = 1'b1;
        serve(1, 1, 4'b1000, 1, 1'b0);

        // Asynchronous reset mid-RUN, then pointer back at 0.
        req[2] = 1'b1;
        n = 0;
        while (grant == 4'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_grant", 32'(grant), 32'(4'b0100));
        repeat (3) @(negedge clk);
        chk("rst_test_busy_before", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 0);
        chk("async_tmr_start", 32'(tmr_start), 0);
        chk("async_tmr_stop", 32'(tmr_stop), 0);
        chk("async_ack", 32'(ack), 0);
        chk("async_busy", 32'(busy), 0);
        req = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1010;
        serve(1, 3, 4'b0, 3, 1'b0);
        serve(3, 2, 4'b0, 2, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
